// File: rtl/facto_pkg.sv
// Shared definitions for the FactoCore job sequencer: register map, FSM states,
// and the bus-access bundle the FSM registers each cycle.
package facto_pkg;

  localparam int RES_W = 128;

  localparam logic [15:0] OFS_START   = 16'h00;
  localparam logic [15:0] OFS_CLEAR   = 16'h08;
  localparam logic [15:0] OFS_DONE    = 16'h10;
  localparam logic [15:0] OFS_INTR_EN = 16'h18;
  localparam logic [15:0] OFS_OPERAND = 16'h20;
  localparam logic [15:0] OFS_RES_H   = 16'h28;
  localparam logic [15:0] OFS_RES_L   = 16'h30;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_OPND,
    ST_W_INTR,
    ST_W_START,
    ST_WAIT,
    ST_R_HI,
    ST_R_LO,
    ST_W_CLR,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic        sel;
    logic        wr;
    logic [15:0] addr;
    logic [63:0] data;
  } bus_t;

endpackage

// File: rtl/facto_sequencer.sv
// Bus master that runs one complete factorial job on a FactoCore slave per
// accepted request and returns the 128-bit result over a valid/ready response.
module facto_sequencer
  import facto_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h7000,
  parameter bit          USE_INTR  = 1'b1,
  parameter logic [31:0] TIMEOUT   = 32'd100000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_operand,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_result,
  output logic             rsp_error,
  output logic             m_sel,
  output logic             m_wr,
  output logic [15:0]      m_addr,
  output logic [63:0]      m_dout,
  input  logic [63:0]      m_din,
  input  logic             interrupt
);

  state_e      r_state;
  bus_t        r_bus;
  logic [63:0] r_operand;
  logic [31:0] r_wait_cnt;
  logic        w_done;

  // Bus pattern presented during a given state; the FSM loads it on entry so
  // the bus pins come straight from flops.
  function automatic bus_t bus_for(input state_e st, input logic [63:0] operand);
    bus_t b;
    b = '0;
    case (st)
      ST_W_OPND:  b = '{sel: 1'b1, wr: 1'b1, addr: BASE_ADDR + OFS_OPERAND, data: operand};
      ST_W_INTR:  b = '{sel: 1'b1, wr: 1'b1, addr: BASE_ADDR + OFS_INTR_EN, data: {63'd0, USE_INTR}};
      ST_W_START: b = '{sel: 1'b1, wr: 1'b1, addr: BASE_ADDR + OFS_START, data: 64'd1};
      ST_WAIT:    if (!USE_INTR) b = '{sel: 1'b1, wr: 1'b0, addr: BASE_ADDR + OFS_DONE, data: 64'd0};
      ST_R_HI:    b = '{sel: 1'b1, wr: 1'b0, addr: BASE_ADDR + OFS_RES_H, data: 64'd0};
      ST_R_LO:    b = '{sel: 1'b1, wr: 1'b0, addr: BASE_ADDR + OFS_RES_L, data: 64'd0};
      ST_W_CLR:   b = '{sel: 1'b1, wr: 1'b1, addr: BASE_ADDR + OFS_CLEAR, data: 64'd1};
      default:    b = '0;
    endcase
    return b;
  endfunction

  assign w_done = USE_INTR ? interrupt : m_din[0];

  assign m_sel  = r_bus.sel;
  assign m_wr   = r_bus.wr;
  assign m_addr = r_bus.addr;
  assign m_dout = r_bus.data;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch reads pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_bus      <= '0;
      r_operand  <= '0;
      r_wait_cnt <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_state    <= ST_W_OPND;
            r_operand  <= req_operand;
            r_bus      <= bus_for(ST_W_OPND, req_operand);
            req_ready  <= 1'b0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
          end
        end
        ST_W_OPND: begin
          r_state <= ST_W_INTR;
          r_bus   <= bus_for(ST_W_INTR, r_operand);
        end
        ST_W_INTR: begin
          r_state <= ST_W_START;
          r_bus   <= bus_for(ST_W_START, r_operand);
        end
        ST_W_START: begin
          r_state    <= ST_WAIT;
          r_bus      <= bus_for(ST_WAIT, r_operand);
          r_wait_cnt <= '0;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 32'd1;
          if (w_done) begin
            r_state <= ST_R_HI;
            r_bus   <= bus_for(ST_R_HI, r_operand);
          end else if (TIMEOUT != 32'd0 && r_wait_cnt == TIMEOUT - 32'd1) begin
            // Abandon the job; the result stays at the zero loaded on accept.
            rsp_error <= 1'b1;
            r_state   <= ST_W_CLR;
            r_bus     <= bus_for(ST_W_CLR, r_operand);
          end
        end
        ST_R_HI: begin
          rsp_result[RES_W-1:64] <= m_din;
          r_state                <= ST_R_LO;
          r_bus                  <= bus_for(ST_R_LO, r_operand);
        end
        ST_R_LO: begin
          rsp_result[63:0] <= m_din;
          r_state          <= ST_W_CLR;
          r_bus            <= bus_for(ST_W_CLR, r_operand);
        end
        ST_W_CLR: begin
          r_state   <= ST_RESP;
          r_bus     <= '0;
          rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state   <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_bus   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_facto_sequencer.sv
// Self-checking bench: two sequencers (interrupt and polling completion) each
// driving a behavioural FactoCore model with configurable latency or a hang.
module tb_facto_sequencer;

  localparam int          TO   = 50;
  localparam logic [15:0] BASE = 16'h7000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid   [2];
  logic         req_ready   [2];
  logic [63:0]  req_operand [2];
  logic         rsp_valid   [2];
  logic         rsp_ready   [2];
  logic [127:0] rsp_result  [2];
  logic         rsp_error   [2];
  logic         m_sel       [2];
  logic         m_wr        [2];
  logic [15:0]  m_addr      [2];
  logic [63:0]  m_dout      [2];
  logic [63:0]  m_din       [2];
  logic         interrupt   [2];

  int           lat_cfg  [2];
  logic         hang_cfg [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  facto_sequencer #(.BASE_ADDR(BASE), .USE_INTR(1'b1), .TIMEOUT(32'(TO))) dut_intr (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_operand(req_operand[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_error(rsp_error[0]),
    .m_sel(m_sel[0]), .m_wr(m_wr[0]), .m_addr(m_addr[0]), .m_dout(m_dout[0]),
    .m_din(m_din[0]), .interrupt(interrupt[0])
  );

  facto_sequencer #(.BASE_ADDR(BASE), .USE_INTR(1'b0), .TIMEOUT(32'(TO))) dut_poll (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_operand(req_operand[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_error(rsp_error[1]),
    .m_sel(m_sel[1]), .m_wr(m_wr[1]), .m_addr(m_addr[1]), .m_dout(m_dout[1]),
    .m_din(m_din[1]), .interrupt(interrupt[1])
  );

  // Reference factorial, modulo 2^128; bench operands never exceed 34.
  function automatic logic [127:0] fact128(input logic [63:0] n);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 2; i <= 40; i++)
      if (64'(i) <= n) r = r * 128'(i);
    return r;
  endfunction

  function automatic logic [63:0] core_read(input logic sel, input logic wr, input logic [15:0] a,
                                            input logic done, input logic [127:0] f);
    if (!sel || wr) return 64'd0;
    case (a)
      BASE + 16'h10: return {63'd0, done};
      BASE + 16'h28: return f[127:64];
      BASE + 16'h30: return f[63:0];
      default:       return 64'd0;
    endcase
  endfunction

  // Behavioural FactoCore: done rises lat_cfg+1 cycles after the start write.
  for (genvar g = 0; g < 2; g++) begin : g_core
    logic [63:0]  core_op;
    logic         core_en, core_done, core_busy;
    int           core_cnt;
    logic [127:0] core_fact;

    assign core_fact    = fact128(core_op);
    assign interrupt[g] = core_done & core_en;
    assign m_din[g]     = core_read(m_sel[g], m_wr[g], m_addr[g], core_done, core_fact);

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        core_op <= '0; core_en <= 1'b0; core_done <= 1'b0; core_busy <= 1'b0; core_cnt <= 0;
      end else begin
        if (core_busy) begin
          if (core_cnt == 0) begin
            core_busy <= 1'b0;
            core_done <= 1'b1;
          end else core_cnt <= core_cnt - 1;
        end
        if (m_sel[g] && m_wr[g]) begin
          case (m_addr[g])
            BASE + 16'h20: core_op <= m_dout[g];
            BASE + 16'h18: core_en <= m_dout[g][0];
            BASE + 16'h00: if (m_dout[g][0] && !hang_cfg[g]) begin
              core_busy <= 1'b1;
              core_cnt  <= lat_cfg[g];
            end
            BASE + 16'h08: core_done <= 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {sel, wr, addr, dout} in cycle c after accept; k is the last WAIT cycle.
  function automatic logic [81:0] exp_bus(input int idx, input int c, input logic [63:0] op,
                                          input int k, input bit hang);
    if (c == 1) return {2'b11, BASE + 16'h20, op};
    if (c == 2) return {2'b11, BASE + 16'h18, (idx == 0) ? 64'd1 : 64'd0};
    if (c == 3) return {2'b11, BASE, 64'd1};
    if (c <= k) return (idx == 1) ? {2'b10, BASE + 16'h10, 64'd0} : 82'd0;
    if (hang)   return (c == k + 1) ? {2'b11, BASE + 16'h08, 64'd1} : 82'd0;
    if (c == k + 1) return {2'b10, BASE + 16'h28, 64'd0};
    if (c == k + 2) return {2'b10, BASE + 16'h30, 64'd0};
    if (c == k + 3) return {2'b11, BASE + 16'h08, 64'd1};
    return 82'd0;
  endfunction

  task automatic check_reset_vals(input int idx, input string tag);
    check({tag, "/req_ready"}, 128'(req_ready[idx]), 128'd1);
    check({tag, "/rsp_valid"}, 128'(rsp_valid[idx]), 128'd0);
    check({tag, "/rsp_error"}, 128'(rsp_error[idx]), 128'd0);
    check({tag, "/rsp_result"}, rsp_result[idx], 128'd0);
    check({tag, "/bus"}, 128'({m_sel[idx], m_wr[idx], m_addr[idx], m_dout[idx]}), 128'd0);
  endtask

  task automatic offer(input int idx, input logic [63:0] op, input string tag);
    int n;
    n = 0;
    while (!req_ready[idx] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check({tag, "/ready_wait"}, 128'(req_ready[idx]), 128'd1);
    req_valid[idx]   = 1'b1;
    req_operand[idx] = op;
    @(negedge clk);
    req_valid[idx]   = 1'b0;
    req_operand[idx] = {$urandom, $urandom};
  endtask

  // One full job; called at a negedge, returns at the negedge after the response handshake.
  task automatic run_job(input int idx, input logic [63:0] op, input int lat, input bit hang,
                         input int hold, input string tag, output logic [127:0] res);
    int c, k, rsp_c, bad_bus, bad_rdy, bad_hold;
    logic [127:0] exp_res;
    lat_cfg[idx]  = lat;
    hang_cfg[idx] = hang;
    rsp_ready[idx] = 1'b0;
    k       = hang ? 3 + TO : 5 + lat;
    rsp_c   = hang ? k + 2 : k + 4;
    exp_res = hang ? 128'd0 : fact128(op);
    offer(idx, op, tag);
    c = 1; bad_bus = 0; bad_rdy = 0; bad_hold = 0;
    while (!rsp_valid[idx] && c < 200) begin
      if ({m_sel[idx], m_wr[idx], m_addr[idx], m_dout[idx]} !== exp_bus(idx, c, op, k, hang))
        bad_bus++;
      if (req_ready[idx] !== 1'b0) bad_rdy++;
      @(negedge clk);
      c++;
    end
    check({tag, "/latency"}, 128'(c), 128'(rsp_c));
    res = rsp_result[idx];
    check({tag, "/result"}, res, exp_res);
    check({tag, "/error"}, 128'(rsp_error[idx]), 128'(hang));
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      if (rsp_valid[idx] !== 1'b1 || rsp_result[idx] !== res || req_ready[idx] !== 1'b0 ||
          {m_sel[idx], m_wr[idx], m_addr[idx], m_dout[idx]} !== 82'd0)
        bad_hold++;
    end
    check({tag, "/bus_bad_cycles"}, 128'(bad_bus), 128'd0);
    check({tag, "/busy_ready_cycles"}, 128'(bad_rdy), 128'd0);
    check({tag, "/hold_bad_cycles"}, 128'(bad_hold), 128'd0);
    rsp_ready[idx] = 1'b1;
    @(negedge clk);
    rsp_ready[idx] = 1'b0;
    check({tag, "/release"}, 128'({rsp_valid[idx], req_ready[idx]}), 128'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] res;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_operand[i] = '0; rsp_ready[i] = 1'b0;
      lat_cfg[i] = 0; hang_cfg[i] = 1'b0;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals(0, "reset_intr");
    check_reset_vals(1, "reset_poll");
    reset_n = 1'b1;
    @(negedge clk);

    run_job(0, 64'd5, 3, 1'b0, 0, "op5", res);
    check("op5_is_120", res, 128'd120);
    run_job(0, 64'd0, 0, 1'b0, 1, "op0", res);
    check("op0_is_1", res, 128'd1);
    run_job(0, 64'd20, 7, 1'b0, 0, "op20", res);
    check("op20_lo", 128'(res[63:0]), 128'(64'd2432902008176640000));
    check("op20_hi", 128'(res[127:64]), 128'd0);
    run_job(1, 64'd25, 6, 1'b0, 0, "poll25", res);
    check("poll25_hi_nonzero", 128'(res[127:64] != 64'd0), 128'd1);
    run_job(0, 64'd7, 0, 1'b1, 2, "timeout", res);
    run_job(1, 64'd4, 2, 1'b0, 20, "hold20", res);
    run_job(1, 64'd6, 1, 1'b0, 0, "after_hold", res);
    check("after_hold_is_720", res, 128'd720);

    // Reset in the middle of a job waiting on a core that never finishes.
    hang_cfg[0] = 1'b1;
    offer(0, 64'd9, "rst_job");
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_vals(0, "midjob_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_job(0, 64'd3, 2, 1'b0, 0, "post_reset", res);
    check("post_reset_is_6", res, 128'd6);

    for (int j = 0; j < 12; j++) begin
      int idx, op, lat, hold;
      idx  = int'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 34));
      lat  = int'($urandom_range(0, 15));
      hold = int'($urandom_range(0, 4));
      run_job(idx, 64'(op), lat, 1'b0, hold, $sformatf("rand%0d_n%0d", j, op), res);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
